// File: rtl/overlap_add.sv
// Overlap-add frame reconstructor: sums the head of each frame with the stored
// tail of the previous one and drains the result through a rate-paced FIFO.
module overlap_add #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned HOP       = 128,
    parameter int unsigned RATE_DIV  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] din,
    input  logic               din_valid,
    input  logic               din_sof,
    output logic signed [15:0] dout,
    output logic               dout_valid,
    output logic               frame_err,
    output logic               ovf
);

    localparam int unsigned DW         = 16;
    localparam int unsigned IDX_W      = $clog2(FRAME_LEN);
    localparam int unsigned TAIL_W     = $clog2(HOP);
    localparam int unsigned FIFO_DEPTH = 256;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam int unsigned SLOT_W     = $clog2(RATE_DIV);

    localparam logic [IDX_W-1:0]  HEAD_LAST  = IDX_W'(HOP - 1);
    localparam logic [IDX_W-1:0]  FRAME_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(RATE_DIV - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic signed [DW-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DW-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        TAIL
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [TAIL_W-1:0]  tail_addr_c;
    logic               head_wr_c, tail_wr_c, frame_done_c, frame_err_c;

    logic signed [DW-1:0] tail_mem [HOP];
    logic                 tail_valid;
    logic signed [DW-1:0] tail_rd_c;
    logic signed [DW:0]   sum_wide_c;
    logic signed [DW-1:0] sum_sat_c;

    logic                 push_q;
    logic signed [DW-1:0] push_data_q;

    logic signed [DW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [SLOT_W-1:0]    slot;
    logic                 pop_c, full_c, wr_en_c;

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Frame sequencing; a sof always (re)starts a frame at index 0
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        tail_addr_c  = idx[TAIL_W-1:0];
        head_wr_c    = 1'b0;
        tail_wr_c    = 1'b0;
        frame_done_c = 1'b0;
        frame_err_c  = 1'b0;
        if (din_valid) begin
            if (din_sof) begin
                frame_err_c = (state != IDLE);
                tail_addr_c = '0;
                head_wr_c   = 1'b1;
                idx_nxt     = IDX_W'(1);
                state_nxt   = HEAD;
            end else begin
                case (state)
                    IDLE: frame_err_c = 1'b1;
                    HEAD: begin
                        head_wr_c = 1'b1;
                        idx_nxt   = idx + IDX_W'(1);
                        if (idx == HEAD_LAST) state_nxt = TAIL;
                    end
                    TAIL: begin
                        tail_wr_c = 1'b1;
                        idx_nxt   = idx + IDX_W'(1);
                        if (idx == FRAME_LAST) begin
                            idx_nxt      = '0;
                            state_nxt    = IDLE;
                            frame_done_c = 1'b1;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // Tail store; contents are don't-care until a frame completes
    always_ff @(posedge clk) begin
        if (!rst && tail_wr_c) tail_mem[tail_addr_c] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst)               tail_valid <= 1'b0;
        else if (frame_done_c) tail_valid <= 1'b1;
    end

    // Saturating head + tail sum
    always_comb begin
        tail_rd_c  = tail_valid ? tail_mem[tail_addr_c] : '0;
        sum_wide_c = {din[DW-1], din} + {tail_rd_c[DW-1], tail_rd_c};
        sum_sat_c  = sum_wide_c[DW-1:0];
        if (sum_wide_c[DW] != sum_wide_c[DW-1]) sum_sat_c = sum_wide_c[DW] ? SAT_MIN : SAT_MAX;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            push_q      <= 1'b0;
            push_data_q <= '0;
            frame_err   <= 1'b0;
        end else begin
            push_q      <= head_wr_c;
            push_data_q <= sum_sat_c;
            frame_err   <= frame_err_c;
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts then
    always_comb begin
        pop_c   = (slot == SLOT_LAST) && (count != '0);
        full_c  = (count == FIFO_FULL);
        wr_en_c = push_q && (!full_c || pop_c);
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en_c) fifo_mem[wr_ptr] <= push_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            slot       <= '0;
            ovf        <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            slot       <= (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
            dout_valid <= pop_c;
            if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                dout   <= fifo_mem[rd_ptr];
            end
            case ({wr_en_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push_q && full_c && !pop_c) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_overlap_add.sv
// Directed bench for overlap_add: frame sums, saturation, framing errors,
// FIFO overflow and reset recovery.
module tb_overlap_add;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] din = '0;
    logic               din_valid = 1'b0;
    logic               din_sof = 1'b0;
    logic signed [15:0] dout;
    logic               dout_valid, frame_err, ovf;

    int errors = 0;
    int checks = 0;
    int k = 0;
    int err_cnt = 0;
    int ovf_k = 0;
    logic signed [15:0] out_q[$];
    int                 out_t[$];

    always #5 clk = ~clk;

    overlap_add #(.FRAME_LEN(256), .HOP(128), .RATE_DIV(16)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sof(din_sof),
        .dout(dout), .dout_valid(dout_valid), .frame_err(frame_err), .ovf(ovf)
    );

    // Edge number since reset release (edge 1 is the first with rst low)
    always @(posedge clk) begin
        if (rst) k = 0;
        else     k = k + 1;
    end

    always @(negedge clk) begin
        if (dout_valid) begin
            out_q.push_back(dout);
            out_t.push_back(k);
        end
        if (frame_err) err_cnt++;
        if (ovf && ovf_k == 0) ovf_k = k;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; din_valid = 1'b0; din_sof = 1'b0; din = '0;
        repeat (2) @(negedge clk);
        out_q.delete(); out_t.delete(); err_cnt = 0; ovf_k = 0;
        rst = 1'b0;
    endtask

    task automatic drive(input logic signed [15:0] v, input logic s);
        @(negedge clk);
        din = v; din_valid = 1'b1; din_sof = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0; din_sof = 1'b0;
        end
    endtask

    task automatic send_frame(input logic signed [15:0] head, input logic signed [15:0] tail);
        for (int i = 0; i < 256; i++) drive((i < 128) ? head : tail, i == 0);
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int c = 0; c < budget && out_q.size() < n; c++) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dout !== 16'sd0) begin errors++; $display("FAIL reset_dout got=%0d exp=0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        idle(40);
        checks++; if (out_q.size() !== 0) begin errors++; $display("FAIL underflow_silent got=%0d exp=0 outputs", out_q.size()); end
        drive(16'sd123, 1'b0);
        idle(40);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL orphan_frame_err got=%0d exp=1 pulses", err_cnt); end
        checks++; if (out_q.size() !== 0) begin errors++; $display("FAIL orphan_dropped got=%0d exp=0 outputs", out_q.size()); end
    endtask

    task automatic test_two_frames();
        do_reset();
        send_frame(16'sd1000, 16'sd1000);
        idle(1792);
        send_frame(16'sd1000, 16'sd1000);
        idle(1);
        wait_out(256, 3000);
        idle(100);
        checks++; if (out_q.size() !== 256) begin errors++; $display("FAIL two_frames_count got=%0d exp=256", out_q.size()); end
        checks++; if (out_t.size() > 0 && out_t[0] !== 16) begin errors++; $display("FAIL first_output_edge got=%0d exp=16", out_t[0]); end
        for (int i = 0; i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== ((i < 128) ? 16'sd1000 : 16'sd2000)) begin
                errors++; $display("FAIL two_frames_value[%0d] got=%0d exp=%0d", i, out_q[i], (i < 128) ? 1000 : 2000);
            end
        end
        for (int i = 1; i < out_t.size(); i++) begin
            checks++;
            if (out_t[i] - out_t[i-1] !== 16) begin
                errors++; $display("FAIL spacing[%0d] got=%0d exp=16", i, out_t[i] - out_t[i-1]);
            end
        end
        checks++; if (dout !== 16'sd2000) begin errors++; $display("FAIL dout_hold got=%0d exp=2000", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL drained_valid got=%b exp=0", dout_valid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL two_frames_ovf got=%b exp=0", ovf); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL two_frames_err got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_saturation();
        logic signed [15:0] exp_v;
        do_reset();
        send_frame(16'sd0, 16'sd30000);
        idle(1792);
        send_frame(16'sd10000, -16'sd30000);
        idle(1792);
        send_frame(-16'sd10000, 16'sd0);
        idle(1);
        wait_out(384, 3000);
        idle(50);
        checks++; if (out_q.size() !== 384) begin errors++; $display("FAIL sat_count got=%0d exp=384", out_q.size()); end
        for (int i = 0; i < out_q.size(); i++) begin
            exp_v = (i < 128) ? 16'sd0 : (i < 256) ? 16'sd32767 : -16'sd32768;
            checks++;
            if (out_q[i] !== exp_v) begin errors++; $display("FAIL sat_value[%0d] got=%0d exp=%0d", i, out_q[i], exp_v); end
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_sof_restart();
        logic signed [15:0] exp_v;
        do_reset();
        for (int i = 0; i < 50; i++) drive(16'sd100, i == 0);
        send_frame(16'sd200, 16'sd300);
        idle(1500);
        send_frame(16'sd5, 16'sd0);
        idle(1);
        wait_out(306, 4000);
        idle(50);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL sof_err_pulses got=%0d exp=1", err_cnt); end
        checks++; if (out_q.size() !== 306) begin errors++; $display("FAIL sof_count got=%0d exp=306", out_q.size()); end
        for (int i = 0; i < out_q.size(); i++) begin
            exp_v = (i < 50) ? 16'sd100 : (i < 178) ? 16'sd200 : 16'sd305;
            checks++;
            if (out_q[i] !== exp_v) begin errors++; $display("FAIL sof_value[%0d] got=%0d exp=%0d", i, out_q[i], exp_v); end
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sof_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] exp_v;
        do_reset();
        send_frame(16'sd1, 16'sd2);
        send_frame(16'sd3, 16'sd4);
        send_frame(16'sd5, 16'sd6);
        idle(1);
        checks++; if (ovf_k !== 549) begin errors++; $display("FAIL ovf_edge got=%0d exp=549", ovf_k); end
        wait_out(296, 6000);
        idle(100);
        checks++; if (out_q.size() !== 296) begin errors++; $display("FAIL b2b_count got=%0d exp=296", out_q.size()); end
        for (int i = 0; i < out_q.size(); i++) begin
            exp_v = (i < 128) ? 16'sd1 : (i < 256) ? 16'sd5 : 16'sd9;
            checks++;
            if (out_q[i] !== exp_v) begin errors++; $display("FAIL b2b_value[%0d] got=%0d exp=%0d", i, out_q[i], exp_v); end
        end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL b2b_err got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_frame(16'sd7, 16'sd9);
        for (int i = 0; i <= 200; i++) drive((i < 128) ? 16'sd7 : 16'sd9, i == 0);
        do_reset();
        checks++; if (dout !== 16'sd0) begin errors++; $display("FAIL midrst_dout got=%0d exp=0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", dout_valid); end
        send_frame(16'sd500, 16'sd500);
        idle(1);
        wait_out(128, 3000);
        idle(50);
        checks++; if (out_q.size() !== 128) begin errors++; $display("FAIL midrst_count got=%0d exp=128", out_q.size()); end
        for (int i = 0; i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== 16'sd500) begin errors++; $display("FAIL midrst_value[%0d] got=%0d exp=500", i, out_q[i]); end
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf got=%b exp=0", ovf); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL midrst_err got=%0d exp=0", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_two_frames();
        test_saturation();
        test_sof_restart();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
